seg7_display_ctrl: RTL and testbench
====================================

Name: seg7_display_ctrl

Overview:
- Sequencing controller in front of the 4-digit seven-segment decoder.
- Shares the display between two requesters: game score and countdown timer.
- Arbitrates between them, converts the granted 14-bit binary value to four BCD digits with a sequential double-dabble engine, and drives the decoder's four digit inputs.
- Also reports which source is currently shown.

Parameters:
- DW, 14: width of the binary value inputs. Must be ≥14 so 9999 is representable.
- MAXVAL, 9999: saturation limit applied before conversion.

Ports:
- clk_i  input  1  system clock. Single clock domain.
- rst_n_i  input  1  asynchronous active-low reset.
- score_req_i  input  1  score requester wants its value displayed. Held until ack.
- score_val_i  input  DW  score value, binary. Sampled on grant.
- score_ack_o  output  1  one-cycle pulse: score request accepted.
- time_req_i  input  1  timer requester wants its value displayed. Held until ack.
- time_val_i  input  DW  timer value, binary. Sampled on grant.
- time_ack_o  output  1  one-cycle pulse: timer request accepted.
- dat1_o  output  4  units digit to decoder.
- dat2_o  output  4  tens digit to decoder.
- dat3_o  output  4  hundreds digit to decoder.
- dat4_o  output  4  thousands digit to decoder.
- src_o  output  1  source of displayed value: 0 = score, 1 = timer.
- upd_o  output  1  one-cycle pulse when dat*_o / src_o change.
- busy_o  output  1  high whenever FSM is not in IDLE.

Behaviour:
Reset values (asynchronous on rst_n_i low):
- dat1_o..dat4_o = 4'hF (decoder blanks).
- score_ack_o = 0, time_ack_o = 0, upd_o = 0, src_o = 0, busy_o = 0.
- FSM = IDLE, shift counter = 0.
- Last-grant register = timer, so score wins the first tie.

FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On a clock edge with any req high, grant one requester and go to SHIFT.
  - Latch min(val, MAXVAL) of the granted source into the binary shift register; clear the BCD register and counter.
  - Assert the granted ack_o for exactly the next cycle.
- SHIFT:
  - Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1.
  - Counter increments each cycle; leave SHIFT after DW shifts → DONE.
- DONE:
  - Register the BCD nibbles into dat1_o..dat4_o and the granted source into src_o.
  - Pulse upd_o for one cycle; go to IDLE.

Arbitration:
- Only one req high: grant it.
- Both high: grant the source not granted last (round-robin); update last-grant on every grant.

Latency:
- Req sampled at edge E0 → ack high during E0..E1.
- Outputs and upd_o change at edge E0+DW+1 (15 cycles at default).
- Next grant is possible no earlier than E0+DW+2.

Handshake and boundary rules:
- Req asserted while busy is not acknowledged; it waits for IDLE.
- Req deasserted before being sampled in IDLE is lost; no ack is issued.
- Value changes after ack do not affect the conversion in flight.
- Val > MAXVAL saturates (e.g. 12000 shows 9999).
- Val = 0 shows digits 0,0,0,0, subject to the optional feature.
- A reset mid-SHIFT aborts the conversion: outputs return to blank, no ack or upd is generated afterwards, and the last-grant register is restored to its reset value.
- Between updates, dat*_o hold their last value (display is static).

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: in DONE, each leading zero nibble (starting from the thousands digit and stopping at the first nonzero) is replaced with 4'hF so the decoder blanks it. The units digit is never blanked; value 0 displays as a single "0".
- Undefined: all four BCD nibbles are passed unmodified; value 0 displays "0000".

Test Plan:
1. Release reset, no requests → dat4..dat1 = F,F,F,F; busy_o = 0; no ack or upd pulses.
2. score_req_i = 1, score_val_i = 1234 → score_ack_o pulses 1 cycle after sampling; 15 cycles after sampling, dat4..dat1 = 1,2,3,4, src_o = 0, upd_o pulses once.
3. score_req_i and time_req_i both high from reset, values 42 and 7 → score served first, then timer. Final display with macro = F,F,F,7 (without macro = 0,0,0,7); src_o = 1; exactly one ack per source.
4. time_val_i = 16383 → saturates, display 9,9,9,9; time_val_i = 0 → F,F,F,0 with macro, 0,0,0,0 without.
5. Assert rst_n_i low during cycle 6 of SHIFT → outputs go blank immediately; after release, busy_o = 0 and no upd_o pulse occurs.
6. score_val_i changes from 500 to 777 one cycle after ack → display shows 5,0,0 in the lower three digits (thousands digit F with macro, 0 without).

Source files
------------

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl
// -----------------------------------------------------------------------------
// Sequencing controller in front of a 4-digit seven-segment decoder.
// Two requesters (game score, countdown timer) share the display. A
// round-robin arbiter grants one of them. The granted value is saturated to
// MAXVAL and converted to four BCD digits by a sequential double-dabble
// engine (one shift per cycle, DW cycles). The result is then registered onto
// the decoder's digit inputs.
//
// Optional feature (compile-time macro SEG7_LEADING_ZERO_BLANK_EN):
//   defined   : leading zero digits are replaced by 4'hF (decoder blank).
//               The units digit is never blanked.
//   undefined : all four BCD digits are passed unmodified.
//
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   score_req_i  score request, held until score_ack_o
//   score_val_i  score value (binary, DW bits), sampled on grant
//   score_ack_o  one-cycle pulse, score request accepted
//   time_req_i   timer request, held until time_ack_o
//   time_val_i   timer value (binary, DW bits), sampled on grant
//   time_ack_o   one-cycle pulse, timer request accepted
//   dat1_o       units digit      dat2_o  tens digit
//   dat3_o       hundreds digit   dat4_o  thousands digit
//   src_o        source of displayed value (0 = score, 1 = timer)
//   upd_o        one-cycle pulse when dat*_o / src_o change
//   busy_o       high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module seg7_display_ctrl #(
  parameter int DW     = 14,
  parameter int MAXVAL = 9999
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          score_req_i,
  input  logic [DW-1:0] score_val_i,
  output logic          score_ack_o,
  input  logic          time_req_i,
  input  logic [DW-1:0] time_val_i,
  output logic          time_ack_o,
  output logic [3:0]    dat1_o,
  output logic [3:0]    dat2_o,
  output logic [3:0]    dat3_o,
  output logic [3:0]    dat4_o,
  output logic          src_o,
  output logic          upd_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int            CW           = $clog2(DW + 1);
  localparam logic [DW-1:0] MAXVAL_C     = DW'(MAXVAL);
  localparam logic [CW-1:0] LAST_SHIFT_C = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_ONE_C    = CW'(1);

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more, so
  // the following left shift carries correctly into the next decimal digit.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Blank zero digits from the thousands digit down to the first nonzero one.
  // The units digit is always shown.
  function automatic logic [15:0] blank_leading(input logic [15:0] bcd);
    logic [15:0] res;
    logic        lead;
    res  = bcd;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (bcd[4*i +: 4] == 4'd0)) begin
        res[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction
`endif

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [DW-1:0] bin_r;
  logic [15:0]   bcd_r;
  logic          last_r;      // last granted source, 1 = timer
  logic          gsrc_r;      // source of the conversion in flight
  logic [15:0]   disp_r;      // {thousands, hundreds, tens, units}
  logic          src_r;
  logic          score_ack_r, time_ack_r, upd_r, busy_r;

  logic          any_req_s;
  logic          grant_time_s;
  logic [DW-1:0] sel_val_s;
  logic [DW-1:0] sat_val_s;
  logic [15:0]   bcd_adj_s;
  logic [15:0]   disp_s;
  logic          score_ack_nxt_s, time_ack_nxt_s, upd_nxt_s, busy_nxt_s;

  // Arbitration: a lone request wins; on a tie the source not granted last wins.
  always_comb begin
    any_req_s = score_req_i | time_req_i;
    if (score_req_i && time_req_i) begin
      grant_time_s = ~last_r;
    end else begin
      grant_time_s = time_req_i;
    end
  end

  // Select the granted value and saturate it to MAXVAL.
  always_comb begin
    if (grant_time_s) begin
      sel_val_s = time_val_i;
    end else begin
      sel_val_s = score_val_i;
    end
    if (sel_val_s > MAXVAL_C) begin
      sat_val_s = MAXVAL_C;
    end else begin
      sat_val_s = sel_val_s;
    end
  end

  // Conversion step and final digit formatting.
  always_comb begin
    bcd_adj_s = dabble_adjust(bcd_r);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    disp_s = blank_leading(bcd_r);
`else
    disp_s = bcd_r;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == LAST_SHIFT_C) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode; these values are registered onto the ports.
  always_comb begin
    score_ack_nxt_s = 1'b0;
    time_ack_nxt_s  = 1'b0;
    upd_nxt_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          score_ack_nxt_s = ~grant_time_s;
          time_ack_nxt_s  = grant_time_s;
        end else begin
          score_ack_nxt_s = 1'b0;
          time_ack_nxt_s  = 1'b0;
        end
      end
      SHIFT:   upd_nxt_s = 1'b0;
      DONE:    upd_nxt_s = 1'b1;
      default: upd_nxt_s = 1'b0;
    endcase
    if (state_nxt_s != IDLE) begin
      busy_nxt_s = 1'b1;
    end else begin
      busy_nxt_s = 1'b0;
    end
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      score_ack_r <= 1'b0;
      time_ack_r  <= 1'b0;
      upd_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      score_ack_r <= score_ack_nxt_s;
      time_ack_r  <= time_ack_nxt_s;
      upd_r       <= upd_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Datapath: grant latch, double-dabble shifter and display registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r  <= '0;
      bin_r  <= '0;
      bcd_r  <= 16'h0000;
      last_r <= 1'b1;
      gsrc_r <= 1'b0;
      disp_r <= 16'hFFFF;
      src_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            bin_r  <= sat_val_s;
            bcd_r  <= 16'h0000;
            cnt_r  <= '0;
            last_r <= grant_time_s;
            gsrc_r <= grant_time_s;
          end
        end
        SHIFT: begin
          {bcd_r, bin_r} <= {bcd_adj_s[14:0], bin_r, 1'b0};
          cnt_r          <= cnt_r + CNT_ONE_C;
        end
        DONE: begin
          disp_r <= disp_s;
          src_r  <= gsrc_r;
        end
        default: begin
          disp_r <= disp_r;
        end
      endcase
    end
  end

  assign dat1_o      = disp_r[3:0];
  assign dat2_o      = disp_r[7:4];
  assign dat3_o      = disp_r[11:8];
  assign dat4_o      = disp_r[15:12];
  assign src_o       = src_r;
  assign score_ack_o = score_ack_r;
  assign time_ack_o  = time_ack_r;
  assign upd_o       = upd_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Testbench for seg7_display_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// transaction-level model (grant -> fixed latency -> decimal digits).
module tb_seg7_display_ctrl;

  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          score_req_i, time_req_i;
  logic [DW-1:0] score_val_i, time_val_i;
  logic          score_ack_o, time_ack_o;
  logic [3:0]    dat1_o, dat2_o, dat3_o, dat4_o;
  logic          src_o, upd_o, busy_o;

  always #5 clk = ~clk;

  seg7_display_ctrl #(.DW(DW), .MAXVAL(9999)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .score_req_i (score_req_i),
    .score_val_i (score_val_i),
    .score_ack_o (score_ack_o),
    .time_req_i  (time_req_i),
    .time_val_i  (time_val_i),
    .time_ack_o  (time_ack_o),
    .dat1_o      (dat1_o),
    .dat2_o      (dat2_o),
    .dat3_o      (dat3_o),
    .dat4_o      (dat4_o),
    .src_o       (src_o),
    .upd_o       (upd_o),
    .busy_o      (busy_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model state.
  int          m_rem;   // cycles until the display update, 0 = idle
  bit          m_last;  // last granted source, 1 = timer
  int          m_val;
  bit          m_gsrc;
  logic [15:0] m_disp;
  bit          m_src, m_ack_s, m_ack_t, m_upd, m_busy;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [15:0] EXP_7   = 16'hFFF7;
  localparam logic [15:0] EXP_42  = 16'hFF42;
  localparam logic [15:0] EXP_0   = 16'hFFF0;
  localparam logic [15:0] EXP_500 = 16'hF500;
`else
  localparam logic [15:0] EXP_7   = 16'h0007;
  localparam logic [15:0] EXP_42  = 16'h0042;
  localparam logic [15:0] EXP_0   = 16'h0000;
  localparam logic [15:0] EXP_500 = 16'h0500;
`endif

  function automatic logic [15:0] digits_of(input int v);
    logic [3:0] d[4];
    bit lead;
    d[0] = 4'(v % 10);
    d[1] = 4'((v / 10) % 10);
    d[2] = 4'((v / 100) % 10);
    d[3] = 4'((v / 1000) % 10);
    lead = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      if (lead && d[i] == 4'd0) d[i] = 4'hF;
      else lead = 1'b0;
    end
`endif
    return {d[3], d[2], d[1], d[0]};
  endfunction

  task automatic model_reset();
    m_rem = 0; m_last = 1'b1; m_val = 0; m_gsrc = 1'b0;
    m_disp = 16'hFFFF; m_src = 1'b0;
    m_ack_s = 1'b0; m_ack_t = 1'b0; m_upd = 1'b0; m_busy = 1'b0;
  endtask

  // One active clock edge of the model, using inputs as seen at the edge.
  task automatic model_edge();
    bit g;
    int v;
    m_ack_s = 1'b0; m_ack_t = 1'b0; m_upd = 1'b0;
    if (m_rem == 0) begin
      if (score_req_i || time_req_i) begin
        if (score_req_i && time_req_i) g = !m_last;
        else g = time_req_i;
        v = g ? int'(time_val_i) : int'(score_val_i);
        m_val  = (v > 9999) ? 9999 : v;
        m_gsrc = g;
        m_last = g;
        m_ack_s = !g;
        m_ack_t = g;
        m_rem  = DW + 1;
        m_busy = 1'b1;
      end
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_disp = digits_of(m_val);
        m_src  = m_gsrc;
        m_upd  = 1'b1;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("disp", {16'h0, dat4_o, dat3_o, dat2_o, dat1_o}, {16'h0, m_disp});
    check("src", {31'h0, src_o}, {31'h0, m_src});
    check("upd", {31'h0, upd_o}, {31'h0, m_upd});
    check("busy", {31'h0, busy_o}, {31'h0, m_busy});
    check("score_ack", {31'h0, score_ack_o}, {31'h0, m_ack_s});
    check("time_ack", {31'h0, time_ack_o}, {31'h0, m_ack_t});
  endtask

  // Advance one clock: model on the edge, compare on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n_i) model_reset();
    else model_edge();
    @(negedge clk);
    compare();
  endtask

  // Run until an update pulse, dropping requests when acknowledged.
  task automatic run_until_upd(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (score_ack_o) score_req_i = 1'b0;
      if (time_ack_o)  time_req_i  = 1'b0;
      if (upd_o) begin
        got = 1'b1;
        break;
      end
    end
    check("upd_timeout", {31'h0, got}, 32'h1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n_i = 1'b0;
    model_reset();
    #1;
    compare();
    cyc();
    cyc();
    rst_n_i = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_val();
    case ($urandom_range(5, 0))
      0:       return 14'd0;
      1:       return 14'd9999;
      2:       return 14'd10000;
      3:       return 14'd16383;
      4:       return DW'($urandom_range(16383, 0));
      default: return DW'($urandom_range(9999, 0));
    endcase
  endfunction

  initial begin
    bit got;
    int ns, nt, nu;
    logic [15:0] first_disp, last_disp;
    bit first_src, last_src;

    rst_n_i = 1'b0; score_req_i = 1'b0; time_req_i = 1'b0;
    score_val_i = 14'd0; time_val_i = 14'd0;
    model_reset();

    // 1: reset state, idle with no requests.
    apply_reset();
    for (int i = 0; i < 5; i++) cyc();
    check("t1_blank", {16'h0, dat4_o, dat3_o, dat2_o, dat1_o}, 32'h0000FFFF);
    check("t1_busy", {31'h0, busy_o}, 32'h0);

    // 2: score 1234 with exact latency.
    score_req_i = 1'b1; score_val_i = 14'd1234;
    cyc();
    check("t2_ack", {31'h0, score_ack_o}, 32'h1);
    score_req_i = 1'b0;
    for (int i = 0; i < 14; i++) cyc();
    check("t2_no_upd_early", {31'h0, upd_o}, 32'h0);
    cyc();
    check("t2_upd", {31'h0, upd_o}, 32'h1);
    check("t2_disp", {16'h0, dat4_o, dat3_o, dat2_o, dat1_o}, 32'h00001234);
    check("t2_src", {31'h0, src_o}, 32'h0);
    cyc();
    check("t2_upd_one", {31'h0, upd_o}, 32'h0);

    // 4: saturation and zero.
    time_req_i = 1'b1; time_val_i = 14'd16383;
    run_until_upd(40, got);
    check("t4_sat", {16'h0, dat4_o, dat3_o, dat2_o, dat1_o}, 32'h00009999);
    check("t4_src", {31'h0, src_o}, 32'h1);
    time_req_i = 1'b1; time_val_i = 14'd0;
    run_until_upd(40, got);
    check("t4_zero", {16'h0, dat4_o, dat3_o, dat2_o, dat1_o}, {16'h0, EXP_0});

    // 6: value change after ack does not disturb the conversion.
    score_req_i = 1'b1; score_val_i = 14'd500;
    cyc();
    check("t6_ack", {31'h0, score_ack_o}, 32'h1);
    score_req_i = 1'b0; score_val_i = 14'd777;
    run_until_upd(40, got);
    check("t6_disp", {16'h0, dat4_o, dat3_o, dat2_o, dat1_o}, {16'h0, EXP_500});

    // 5: reset in the sixth SHIFT cycle of a score conversion.
    score_req_i = 1'b1; score_val_i = 14'd4321;
    cyc();
    score_req_i = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    #2;
    rst_n_i = 1'b0;
    model_reset();
    #1;
    check("t5_blank", {16'h0, dat4_o, dat3_o, dat2_o, dat1_o}, 32'h0000FFFF);
    check("t5_busy", {31'h0, busy_o}, 32'h0);
    cyc();
    rst_n_i = 1'b1;
    nu = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (upd_o) nu++;
    end
    check("t5_no_upd", nu, 0);

    // 3: both requests high from reset; score first, then timer.
    @(negedge clk);
    rst_n_i = 1'b0;
    model_reset();
    score_req_i = 1'b1; score_val_i = 14'd42;
    time_req_i  = 1'b1; time_val_i  = 14'd7;
    cyc();
    rst_n_i = 1'b1;
    ns = 0; nt = 0; nu = 0;
    first_disp = 16'h0; last_disp = 16'h0; first_src = 1'b1; last_src = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (score_ack_o) begin ns++; score_req_i = 1'b0; end
      if (time_ack_o)  begin nt++; time_req_i  = 1'b0; end
      if (upd_o) begin
        nu++;
        if (nu == 1) begin
          first_disp = {dat4_o, dat3_o, dat2_o, dat1_o}; first_src = src_o;
        end
        last_disp = {dat4_o, dat3_o, dat2_o, dat1_o}; last_src = src_o;
      end
    end
    check("t3_score_acks", ns, 1);
    check("t3_time_acks", nt, 1);
    check("t3_upds", nu, 2);
    check("t3_first_src", {31'h0, first_src}, 32'h0);
    check("t3_first_disp", {16'h0, first_disp}, {16'h0, EXP_42});
    check("t3_last_src", {31'h0, last_src}, 32'h1);
    check("t3_last_disp", {16'h0, last_disp}, {16'h0, EXP_7});

    // Randomized traffic: requesters hold until ack, sometimes give up early.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (score_req_i && score_ack_o) begin
        score_req_i = 1'b0;
        if ($urandom_range(1, 0) == 0) score_val_i = rand_val();
      end else if (score_req_i && $urandom_range(39, 0) == 0) begin
        score_req_i = 1'b0;
      end else if (!score_req_i && $urandom_range(7, 0) == 0) begin
        score_req_i = 1'b1;
        score_val_i = rand_val();
      end
      if (time_req_i && time_ack_o) begin
        time_req_i = 1'b0;
        if ($urandom_range(1, 0) == 0) time_val_i = rand_val();
      end else if (time_req_i && $urandom_range(39, 0) == 0) begin
        time_req_i = 1'b0;
      end else if (!time_req_i && $urandom_range(7, 0) == 0) begin
        time_req_i = 1'b1;
        time_val_i = rand_val();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
